// File: rtl/btn_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : btn_cmd_pkg
// Brief    : Press-code constants and code-to-command decode helpers.
// Revision : 1.0 - initial release
// ============================================================================
package btn_cmd_pkg;

    localparam logic [2:0] CODE_NEXT     = 3'd0;
    localparam logic [2:0] CODE_RET_LAST = 3'd1;
    localparam logic [2:0] CODE_CONFIRM  = 3'd2;
    localparam logic [2:0] CODE_DELETE   = 3'd3;
    localparam logic [2:0] CODE_RET_INIT = 3'd4;
    localparam logic [2:0] CODE_IDLE     = 3'd7;

    localparam int NUM_CMDS = 5;

    function automatic logic is_cmd_code(input logic [2:0] code);
        return (code <= CODE_RET_INIT);
    endfunction

    function automatic logic is_illegal_code(input logic [2:0] code);
        return (code == 3'd5) || (code == 3'd6);
    endfunction

    function automatic logic [NUM_CMDS-1:0] code_to_onehot(input logic [2:0] code);
        logic [NUM_CMDS-1:0] onehot;
        onehot = '0;
        for (int i = 0; i < NUM_CMDS; i++) begin
            onehot[i] = (code == 3'(i));
        end
        return onehot;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cmd_fifo
// Brief    : Generic synchronous FIFO with free-running wrap-around counters.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_fifo #(
    parameter int  WIDTH  = 3,
    parameter int  DEPTH  = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [WIDTH-1:0]  i_data,
    output logic [WIDTH-1:0]  o_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_level
);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("cmd_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]  r_wr_cnt;
    logic [ADDR_W:0]  r_rd_cnt;
    logic             w_pop_fire;
    logic             w_push_fire;

    // The extra counter bit distinguishes full from empty when the indices match.
    assign o_level     = r_wr_cnt - r_rd_cnt;
    assign o_full      = (o_level == (ADDR_W+1)'(DEPTH));
    assign o_empty     = (o_level == '0);
    assign w_pop_fire  = i_pop && !o_empty;
    assign w_push_fire = i_push && (!o_full || w_pop_fire);
    assign o_data      = r_mem[r_rd_cnt[ADDR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (w_push_fire) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end
            if (w_pop_fire) begin
                r_rd_cnt <= r_rd_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_fire) begin
            r_mem[r_wr_cnt[ADDR_W-1:0]] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/button_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : button_cmd_decoder
// Brief    : Edge-detects debounced press codes and queues one-hot commands.
// Revision : 1.0 - initial release
// ============================================================================
module button_cmd_decoder
    import btn_cmd_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          i_press,
    output logic                o_cmd_valid,
    input  logic                i_cmd_ready,
    output logic [NUM_CMDS-1:0] o_cmd,
    output logic [2:0]          o_cmd_code,
    output logic [ADDR_W:0]     o_level,
    output logic                o_overflow,
    output logic                o_bad_code,
    input  logic                i_clr_flags
);

    logic [2:0] r_press_prev;
    logic       r_overflow;
    logic       r_bad_code;
    logic       w_event;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic       w_drop;
    logic [2:0] w_head;

    assign w_event = is_cmd_code(i_press) && (i_press != r_press_prev);
    assign w_pop   = !w_empty && i_cmd_ready;
    assign w_drop  = w_event && w_full && !w_pop;

    cmd_fifo #(
        .WIDTH (3),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_event),
        .i_pop   (w_pop),
        .i_data  (i_press),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_level)
    );

    // Illegal codes still update the history so a later valid code edge-detects cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_press_prev <= CODE_IDLE;
        end else begin
            r_press_prev <= i_press;
        end
    end

    // Set has priority over clear so no event is lost to a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_bad_code <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_clr_flags) begin
                r_overflow <= 1'b0;
            end
            if (is_illegal_code(i_press)) begin
                r_bad_code <= 1'b1;
            end else if (i_clr_flags) begin
                r_bad_code <= 1'b0;
            end
        end
    end

    assign o_cmd_valid = !w_empty;
    assign o_cmd_code  = w_empty ? CODE_IDLE : w_head;
    assign o_cmd       = w_empty ? '0 : code_to_onehot(w_head);
    assign o_overflow  = r_overflow;
    assign o_bad_code  = r_bad_code;

endmodule
`default_nettype wire

// File: tb/tb_button_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_cmd_decoder
// Brief    : Scoreboard bench for button_cmd_decoder with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_cmd_decoder;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic             clk;
    logic             rst_n;
    logic [2:0]       i_press;
    logic             i_cmd_ready;
    logic             i_clr_flags;
    logic             o_cmd_valid;
    logic [4:0]       o_cmd;
    logic [2:0]       o_cmd_code;
    logic [ADDR_W:0]  o_level;
    logic             o_overflow;
    logic             o_bad_code;

    int unsigned n_cmp;
    int unsigned n_bad;

    logic [2:0] exp_q[$];
    int         m_level;
    logic [2:0] m_prev;
    logic       m_ovf;
    logic       m_bad;

    button_cmd_decoder #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_press     (i_press),
        .o_cmd_valid (o_cmd_valid),
        .i_cmd_ready (i_cmd_ready),
        .o_cmd       (o_cmd),
        .o_cmd_code  (o_cmd_code),
        .o_level     (o_level),
        .o_overflow  (o_overflow),
        .o_bad_code  (o_bad_code),
        .i_clr_flags (i_clr_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a press is an event when it names a command and differs from
    // last cycle's press; it is kept if there is room or the head leaves this cycle.
    always @(posedge clk or negedge rst_n) begin : model
        logic evt;
        logic pop;
        logic acc;
        if (!rst_n) begin
            m_prev  <= 3'd7;
            m_level <= 0;
            m_ovf   <= 1'b0;
            m_bad   <= 1'b0;
            exp_q.delete();
        end else begin
            evt = (i_press <= 3'd4) && (i_press != m_prev);
            pop = (m_level > 0) && i_cmd_ready;
            acc = evt && ((m_level < DEPTH) || pop);
            if (evt && !acc)                       m_ovf <= 1'b1;
            else if (i_clr_flags)                  m_ovf <= 1'b0;
            if (i_press == 3'd5 || i_press == 3'd6) m_bad <= 1'b1;
            else if (i_clr_flags)                  m_bad <= 1'b0;
            if (acc) exp_q.push_back(i_press);
            m_level <= m_level + int'(acc) - int'(pop);
            m_prev  <= i_press;
        end
    end

    // Monitor: compares every cycle and retires the head when the handshake fires.
    always @(negedge clk) begin
        chk("level",    32'(o_level),    32'(m_level));
        chk("valid",    32'(o_cmd_valid), 32'(m_level > 0));
        chk("overflow", 32'(o_overflow), 32'(m_ovf));
        chk("bad_code", 32'(o_bad_code), 32'(m_bad));
        if (o_cmd_valid) begin
            if (exp_q.size() == 0) begin
                chk("head_present", 32'(exp_q.size()), 32'd1);
            end else begin
                chk("cmd_code", 32'(o_cmd_code), 32'(exp_q[0]));
                chk("cmd",      32'(o_cmd),      32'(1) << exp_q[0]);
                if (i_cmd_ready) void'(exp_q.pop_front());
            end
        end else begin
            chk("idle_cmd",  32'(o_cmd),      32'd0);
            chk("idle_code", 32'(o_cmd_code), 32'd7);
        end
    end

    task automatic step(input logic [2:0] p, input logic rdy, input logic clr);
        i_press     = p;
        i_cmd_ready = rdy;
        i_clr_flags = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rst_n       = 1'b0;
        i_press     = 3'd7;
        i_cmd_ready = 1'b0;
        i_clr_flags = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic decode
        repeat (3) step(3'd7, 1'b1, 1'b0);
        step(3'd2, 1'b1, 1'b0);
        repeat (3) step(3'd7, 1'b1, 1'b0);

        // Held code yields a single entry
        repeat (10) step(3'd4, 1'b0, 1'b0);
        step(3'd7, 1'b0, 1'b0);
        repeat (3) step(3'd7, 1'b1, 1'b0);

        // Back-to-back codes, then drain
        step(3'd0, 1'b0, 1'b0);
        step(3'd1, 1'b0, 1'b0);
        step(3'd3, 1'b0, 1'b0);
        repeat (2) step(3'd7, 1'b0, 1'b0);
        repeat (4) step(3'd7, 1'b1, 1'b0);

        // Overflow, then full + push + pop with no overflow
        step(3'd0, 1'b0, 1'b0);
        step(3'd1, 1'b0, 1'b0);
        step(3'd2, 1'b0, 1'b0);
        step(3'd3, 1'b0, 1'b0);
        step(3'd4, 1'b0, 1'b0);
        step(3'd0, 1'b0, 1'b0);
        step(3'd7, 1'b0, 1'b1);
        step(3'd1, 1'b1, 1'b0);
        step(3'd7, 1'b0, 1'b0);
        repeat (6) step(3'd7, 1'b1, 1'b0);

        // Illegal codes and clear priority
        step(3'd5, 1'b0, 1'b0);
        step(3'd7, 1'b0, 1'b1);
        step(3'd6, 1'b0, 1'b1);
        step(3'd7, 1'b0, 1'b0);
        step(3'd7, 1'b0, 1'b1);

        // Asynchronous reset mid-stream
        step(3'd6, 1'b0, 1'b0);
        step(3'd0, 1'b0, 1'b0);
        step(3'd1, 1'b0, 1'b0);
        step(3'd2, 1'b0, 1'b0);
        step(3'd7, 1'b0, 1'b0);
        chk("pre_rst_level", 32'(o_level), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid",    32'(o_cmd_valid), 32'd0);
        chk("rst_level",    32'(o_level),     32'd0);
        chk("rst_overflow", 32'(o_overflow),  32'd0);
        chk("rst_bad_code", 32'(o_bad_code),  32'd0);
        chk("rst_cmd",      32'(o_cmd),       32'd0);
        chk("rst_code",     32'(o_cmd_code),  32'd7);
        i_press = 3'd7;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(3'd3, 1'b1, 1'b0);
        repeat (2) step(3'd7, 1'b1, 1'b0);

        // Randomized phases with varying consumer back-pressure
        for (int ph = 0; ph < 4; ph++) begin
            logic [2:0] p;
            p = 3'd7;
            for (int c = 0; c < 500; c++) begin
                logic rdy;
                if ($urandom_range(0, 2) != 0) p = 3'($urandom_range(0, 7));
                rdy = ($urandom_range(0, 3) < ph);
                step(p, rdy, ($urandom_range(0, 15) == 0));
            end
        end

        repeat (8) step(3'd7, 1'b1, 1'b0);
        chk("drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_cmd_decoder.md
# button_cmd_decoder

Receives the 3-bit press code from the button debounce encoder and turns each new press into a one-hot command. Commands are held in a small FIFO and delivered to the game/menu control FSM over a valid/ready handshake, so presses are not lost while the consumer is busy. Malformed codes and dropped presses are flagged in sticky status bits. The block sits between the input debounce stage and the top-level control FSM.

## Interface
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.
- ADDR_W, 2, log2(DEPTH).
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- press  in  3  encoder code. Valid codes: 0 = next, 1 = return_last_state, 2 = confirm, 3 = delete_or_last, 4 = return_initial_state. 7 = idle. 5 and 6 are illegal.
- cmd_valid  out  1  head-of-FIFO command is available.
- cmd_ready  in  1  consumer accepts the command.
- cmd  out  5  one-hot command; bit n corresponds to code n. Zero when cmd_valid = 0.
- cmd_code  out  3  binary code of the head entry. Reads 7 when cmd_valid = 0.
- level  out  ADDR_W+1  number of occupied FIFO entries.
- overflow  out  1  sticky; a press was dropped because the FIFO was full.
- bad_code  out  1  sticky; code 5 or 6 was seen on press.
- clr_flags  in  1  clears overflow and bad_code.

## Operation
- press_r is a register holding the previous cycle's press; it resets to 7.
- Event condition: press is in 0..4 and press differs from press_r.
  - A code held for several cycles produces one event.
  - A direct change between two valid codes (for example 2 → 3) produces a new event.
  - The sequence 2, 7, 2 produces two events.
- Each event pushes press into the FIFO.
- Pop occurs when cmd_valid = 1 and cmd_ready = 1.
- Push when full:
  - accepted if a pop happens in the same cycle;
  - otherwise the new press is dropped, the FIFO is unchanged, and overflow is set.
- Push and pop in the same cycle when not empty: level is unchanged.
- Push when empty: the entry becomes visible on the following cycle. There is no bypass.
- Codes 5 and 6: no push; bad_code is set. press_r still updates.
- clr_flags clears both sticky bits. If a set condition occurs in the same cycle, the set wins.
- Pointers are ADDR_W bits and wrap naturally. level is computed as wr_cnt - rd_cnt using ADDR_W+1-bit counters.
- The block has no state machine beyond the FIFO pointers; the edge detector is the only control path.

## Timing
- Reset values:
  - cmd_valid = 0, cmd = 0, cmd_code = 7, level = 0;
  - overflow = 0, bad_code = 0;
  - press_r = 7, FIFO pointers = 0.
- Latency: press event at edge N (sampled) → cmd_valid = 1 after edge N, visible in cycle N+1, when the FIFO was empty.
- cmd, cmd_code and cmd_valid are registered or derived directly from registered state. cmd_ready has no combinational path to any output except through the next edge.
- Once cmd_valid is high, the head entry is stable until it is popped.
- Reset asserted mid-operation empties the FIFO immediately (asynchronously) and clears the flags. Any press in flight is discarded.
- Throughput: one push and one pop per cycle.

## Structure
- Package btn_cmd_pkg holds:
  - code constants: CODE_NEXT = 0, CODE_RET_LAST = 1, CODE_CONFIRM = 2, CODE_DELETE = 3, CODE_RET_INIT = 4, CODE_IDLE = 7;
  - NUM_CMDS = 5;
  - a function mapping a code to the one-hot command.
- Sub-module cmd_fifo: a generic synchronous FIFO.
  - Parameters: WIDTH = 3, DEPTH.
  - Ports: push, pop, data in/out, full, empty, level.
- The top level contains the edge detector, the code validation, the sticky flags and the one-hot decode.

## Test plan
- Basic decode: press = 7 for 3 cycles, then 2 for 1 cycle, with cmd_ready = 1 → cmd_valid = 1 for one cycle, one cycle after the press; cmd = 5'b00100, cmd_code = 2.
- Held code: press = 4 for 10 cycles, cmd_ready = 0 → level = 1, only one entry; cmd = 5'b10000.
- Back-to-back codes: press sequence 0, 1, 3 on consecutive cycles, with cmd_ready = 0 → level = 3. Draining yields cmd 00001, then 00010, then 01000.
- Overflow: 6 distinct events with cmd_ready = 0 and DEPTH = 4 → level = 4, overflow = 1, the first 4 codes are retained in order. Full + push + pop in the same cycle → no overflow.
- Illegal codes: press = 5 → bad_code = 1, level unchanged. clr_flags pulse → 0. clr_flags together with press = 6 in the same cycle → bad_code stays 1.
- Reset mid-stream: level = 3, assert rst_n low asynchronously between edges → cmd_valid = 0, level = 0 and both flags = 0 immediately. The first press after release decodes normally.
